// File: rtl/cfa_pixel_fetch_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cfa_pixel_fetch_if
// Bundles every non-clock/reset signal of the CFA pixel fetch stage:
//   generator side : start, addrIn, addrValidIn, bayerIn, rowIn, colIn, enOut
//   memory side    : memAddr, memRe, memData
//   output side    : outPixel, outBayer, outRow, outCol, outValid, outReady,
//                    fifoCount, overflowErr
// Modports:
//   slave  - the fetch stage itself
//   master - its environment (generator, raw-frame memory, demosaic stage)
// ---------------------------------------------------------------------------
interface cfa_pixel_fetch_if #(
  parameter int rowBitWidth   = 11,
  parameter int colBitWidth   = 11,
  parameter int pixelBitWidth = 8,
  parameter int fifoDepth     = 4
);
  localparam int addrBitWidth  = rowBitWidth + colBitWidth;
  localparam int countBitWidth = $clog2(fifoDepth) + 1;

  logic                     start;
  logic [addrBitWidth-1:0]  addrIn;
  logic                     addrValidIn;
  logic [1:0]               bayerIn;
  logic [rowBitWidth-1:0]   rowIn;
  logic [colBitWidth-1:0]   colIn;
  logic                     enOut;

  logic [addrBitWidth-1:0]  memAddr;
  logic                     memRe;
  logic [pixelBitWidth-1:0] memData;

  logic [pixelBitWidth-1:0] outPixel;
  logic [1:0]               outBayer;
  logic [rowBitWidth-1:0]   outRow;
  logic [colBitWidth-1:0]   outCol;
  logic                     outValid;
  logic                     outReady;
  logic [countBitWidth-1:0] fifoCount;
  logic                     overflowErr;

  modport slave (
    input  start, addrIn, addrValidIn, bayerIn, rowIn, colIn, memData, outReady,
    output enOut, memAddr, memRe, outPixel, outBayer, outRow, outCol, outValid,
           fifoCount, overflowErr
  );

  modport master (
    output start, addrIn, addrValidIn, bayerIn, rowIn, colIn, memData, outReady,
    input  enOut, memAddr, memRe, outPixel, outBayer, outRow, outCol, outValid,
           fifoCount, overflowErr
  );
endinterface

// File: rtl/cfa_pixel_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cfa_pixel_fetch
// Sits behind the raster-address / Bayer-symbol generator. Each accepted
// pixel address becomes a raw-frame memory read; the returned pixel is
// re-joined with its Bayer symbol, row and column and queued in a small FIFO
// for the demosaic stage. The generator is throttled through enOut with
// credits so that every read already issued is guaranteed a FIFO slot.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - cfa_pixel_fetch_if.slave (generator, memory and output signals)
// ---------------------------------------------------------------------------
module cfa_pixel_fetch #(
  parameter int rowBitWidth   = 11,
  parameter int colBitWidth   = 11,
  parameter int pixelBitWidth = 8,
  parameter int readLatency   = 2,
  parameter int fifoDepth     = 4
) (
  input  logic              clk,
  input  logic              rst,
  cfa_pixel_fetch_if.slave  bus
);

  localparam int addrBitWidth = rowBitWidth + colBitWidth;
  localparam int ptrBitWidth  = $clog2(fifoDepth);
  localparam int cntBitWidth  = ptrBitWidth + 1;
  localparam int flBitWidth   = $clog2(readLatency + 1) + 1;
  // Wide enough to hold fifoCount + inFlight without wrapping.
  localparam int sumBitWidth  = ((cntBitWidth > flBitWidth) ? cntBitWidth : flBitWidth) + 1;

  localparam logic [ptrBitWidth-1:0] ptr_one = {{(ptrBitWidth-1){1'b0}}, 1'b1};
  localparam logic [cntBitWidth-1:0] cnt_one = {{(cntBitWidth-1){1'b0}}, 1'b1};
  localparam logic [cntBitWidth-1:0] cnt_full = cntBitWidth'(fifoDepth);
  localparam logic [sumBitWidth-1:0] sum_limit = sumBitWidth'(fifoDepth);

  // Sideband pipe: stage readLatency-1 lines up with memData.
  logic [readLatency-1:0]   pipe_valid_r;
  logic [1:0]               pipe_bayer_r [readLatency];
  logic [rowBitWidth-1:0]   pipe_row_r   [readLatency];
  logic [colBitWidth-1:0]   pipe_col_r   [readLatency];

  // Output FIFO storage and control.
  logic [pixelBitWidth-1:0] fifo_pixel_r [fifoDepth];
  logic [1:0]               fifo_bayer_r [fifoDepth];
  logic [rowBitWidth-1:0]   fifo_row_r   [fifoDepth];
  logic [colBitWidth-1:0]   fifo_col_r   [fifoDepth];
  logic [ptrBitWidth-1:0]   wr_ptr_r;
  logic [ptrBitWidth-1:0]   rd_ptr_r;
  logic [cntBitWidth-1:0]   count_r;
  logic                     overflow_r;

  logic [flBitWidth-1:0]    inflight_s;
  logic [sumBitWidth-1:0]   credit_sum_s;
  logic                     en_s;
  logic                     accept_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     empty_s;
  logic                     full_s;
  logic                     wr_en_s;
  logic                     flush_s;

  // Count reads still travelling through the memory.
  always_comb begin
    inflight_s = {flBitWidth{1'b0}};
    for (int i = 0; i < readLatency; i++) begin
      inflight_s = inflight_s + {{(flBitWidth-1){1'b0}}, pipe_valid_r[i]};
    end
  end

  // Credit, handshake and FIFO control decode.
  always_comb begin
    credit_sum_s = sumBitWidth'(count_r) + sumBitWidth'(inflight_s);
    // Built from registered state only, so a pop returns its credit one
    // cycle later and outReady never reaches the generator combinationally.
    en_s         = (credit_sum_s < sum_limit);
    accept_s     = bus.addrValidIn & en_s;
    push_s       = pipe_valid_r[readLatency-1];
    empty_s      = (count_r == {cntBitWidth{1'b0}});
    full_s       = (count_r == cnt_full);
    pop_s        = ~empty_s & bus.outReady;
    // A full FIFO can still take a write when the head leaves this cycle.
    wr_en_s      = push_s & (~full_s | pop_s);
    flush_s      = rst | bus.start;
  end

  assign bus.enOut       = en_s;
  assign bus.memRe       = accept_s;
  assign bus.memAddr     = bus.addrIn;
  assign bus.outPixel    = fifo_pixel_r[rd_ptr_r];
  assign bus.outBayer    = fifo_bayer_r[rd_ptr_r];
  assign bus.outRow      = fifo_row_r[rd_ptr_r];
  assign bus.outCol      = fifo_col_r[rd_ptr_r];
  assign bus.outValid    = ~empty_s;
  assign bus.fifoCount   = count_r;
  assign bus.overflowErr = overflow_r;

  // Sideband shift register; it never stalls, and a flush kills every
  // read still in flight by clearing its valid bit.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      pipe_valid_r <= {readLatency{1'b0}};
      for (int i = 0; i < readLatency; i++) begin
        pipe_bayer_r[i] <= 2'b00;
        pipe_row_r[i]   <= {rowBitWidth{1'b0}};
        pipe_col_r[i]   <= {colBitWidth{1'b0}};
      end
    end else begin
      pipe_valid_r[0] <= accept_s;
      pipe_bayer_r[0] <= bus.bayerIn;
      pipe_row_r[0]   <= bus.rowIn;
      pipe_col_r[0]   <= bus.colIn;
      for (int i = 1; i < readLatency; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_bayer_r[i] <= pipe_bayer_r[i-1];
        pipe_row_r[i]   <= pipe_row_r[i-1];
        pipe_col_r[i]   <= pipe_col_r[i-1];
      end
    end
  end

  // FIFO storage: memData and its sideband are written together.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      for (int i = 0; i < fifoDepth; i++) begin
        fifo_pixel_r[i] <= {pixelBitWidth{1'b0}};
        fifo_bayer_r[i] <= 2'b00;
        fifo_row_r[i]   <= {rowBitWidth{1'b0}};
        fifo_col_r[i]   <= {colBitWidth{1'b0}};
      end
    end else if (wr_en_s) begin
      fifo_pixel_r[wr_ptr_r] <= bus.memData;
      fifo_bayer_r[wr_ptr_r] <= pipe_bayer_r[readLatency-1];
      fifo_row_r[wr_ptr_r]   <= pipe_row_r[readLatency-1];
      fifo_col_r[wr_ptr_r]   <= pipe_col_r[readLatency-1];
    end else begin
      fifo_pixel_r[wr_ptr_r] <= fifo_pixel_r[wr_ptr_r];
    end
  end

  // FIFO pointers; depth is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wr_ptr_r <= {ptrBitWidth{1'b0}};
      rd_ptr_r <= {ptrBitWidth{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_one;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_one;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      count_r <= {cntBitWidth{1'b0}};
    end else begin
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + cnt_one;
        2'b01:   count_r <= count_r - cnt_one;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag; survives a frame-start flush, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (bus.start) begin
      overflow_r <= overflow_r;
    end else if (push_s & full_s & ~pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_cfa_pixel_fetch.sv
`timescale 1ns/1ps
// Bench for cfa_pixel_fetch: a queue-based model of credits, memory round
// trip and output FIFO is compared against the DUT every cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_cfa_pixel_fetch;
  localparam int RW  = 11;
  localparam int CW  = 11;
  localparam int PW  = 8;
  localparam int LAT = 2;
  localparam int DEP = 4;
  localparam int AW  = RW + CW;

  logic clk;
  logic rst;

  cfa_pixel_fetch_if #(.rowBitWidth(RW), .colBitWidth(CW), .pixelBitWidth(PW),
                       .fifoDepth(DEP)) bus ();

  cfa_pixel_fetch #(.rowBitWidth(RW), .colBitWidth(CW), .pixelBitWidth(PW),
                    .readLatency(LAT), .fifoDepth(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Raw-frame memory content.
  function automatic logic [PW-1:0] pix_of(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h99;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fixed-latency memory model.
  logic [AW-1:0] mem_a_r [LAT];
  logic          mem_v_r [LAT];
  always @(posedge clk) begin
    mem_a_r[0] <= bus.memAddr;
    mem_v_r[0] <= bus.memRe;
    for (int i = 1; i < LAT; i++) begin
      mem_a_r[i] <= mem_a_r[i-1];
      mem_v_r[i] <= mem_v_r[i-1];
    end
  end
  always_comb begin
    bus.memData = mem_v_r[LAT-1] ? pix_of(mem_a_r[LAT-1]) : 8'hEE;
  end

  // Behavioural model.
  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    bayer;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    int            cyc;
  } item_t;

  item_t fifo_q[$];
  item_t fl_q[$];
  bit    model_on = 1'b0;
  bit    m_ovf    = 1'b0;
  int    cyc      = 0;

  always @(negedge clk) begin : model
    item_t it;
    bit    exp_en;
    bit    acc;
    bit    pop;
    exp_en = (fifo_q.size() + fl_q.size()) < DEP;
    acc    = bus.addrValidIn && exp_en;
    if (model_on) begin
      check("m_enOut",     64'(bus.enOut),       64'(exp_en));
      check("m_memRe",     64'(bus.memRe),       64'(acc));
      check("m_memAddr",   64'(bus.memAddr),     64'(bus.addrIn));
      check("m_outValid",  64'(bus.outValid),    64'(fifo_q.size() > 0));
      check("m_fifoCount", 64'(bus.fifoCount),   64'(fifo_q.size()));
      check("m_overflow",  64'(bus.overflowErr), 64'(m_ovf));
      if (fifo_q.size() > 0) begin
        check("m_head",
              64'({bus.outPixel, bus.outBayer, bus.outRow, bus.outCol}),
              64'({pix_of(fifo_q[0].addr), fifo_q[0].bayer, fifo_q[0].row, fifo_q[0].col}));
      end
    end
    if (rst) begin
      fifo_q.delete();
      fl_q.delete();
      m_ovf    = 1'b0;
      model_on = 1'b1;
    end else if (bus.start) begin
      fifo_q.delete();
      fl_q.delete();
    end else begin
      pop = (fifo_q.size() > 0) && bus.outReady;
      if (pop) void'(fifo_q.pop_front());
      if (fl_q.size() > 0 && fl_q[0].cyc == cyc - LAT) begin
        it = fl_q.pop_front();
        if (fifo_q.size() >= DEP) m_ovf = 1'b1;
        else fifo_q.push_back(it);
      end
      if (acc) fl_q.push_back('{bus.addrIn, bus.bayerIn, bus.rowIn, bus.colIn, cyc});
    end
    cyc++;
  end

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [1:0] b,
                       input logic [RW-1:0] r, input logic [CW-1:0] c,
                       input logic rdy, input logic st, input logic rs);
    @(posedge clk);
    #1;
    rst             = rs;
    bus.addrValidIn = v;
    bus.addrIn      = a;
    bus.bayerIn     = b;
    bus.rowIn       = r;
    bus.colIn       = c;
    bus.outReady    = rdy;
    bus.start       = st;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 22'h0, 2'd0, 11'd0, 11'd0, rdy, 1'b0, 1'b0);
  endtask

  int reads;
  int n_out;
  int n_en_low;
  int first;
  int last;
  int stale;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.addrValidIn = 1'b0;
    bus.addrIn = 22'h0;
    bus.bayerIn = 2'd0;
    bus.rowIn = 11'd0;
    bus.colIn = 11'd0;
    bus.outReady = 1'b0;

    // Reset with addresses offered: reads still follow accept.
    for (int i = 0; i < 3; i++) drive(1'b1, 22'(i + 7), 2'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_memRe", 64'(bus.memRe), 64'd1);
    idle(1, 1'b0);
    @(negedge clk);
    check("rst_outValid", 64'(bus.outValid), 64'd0);
    check("rst_fifoCount", 64'(bus.fifoCount), 64'd0);
    check("rst_enOut", 64'(bus.enOut), 64'd1);
    check("rst_overflow", 64'(bus.overflowErr), 64'd0);
    check("rst_outPixel", 64'(bus.outPixel), 64'd0);
    idle(3, 1'b0);

    // Single pixel: latency 3.
    drive(1'b1, 22'h000A5, 2'd2, 11'd0, 11'd165, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("sp_memRe", 64'(bus.memRe), 64'd1);
    check("sp_memAddr", 64'(bus.memAddr), 64'h000A5);
    idle(2, 1'b1);
    @(negedge clk);
    check("sp_early", 64'(bus.outValid), 64'd0);
    idle(1, 1'b1);
    @(negedge clk);
    check("sp_outValid", 64'(bus.outValid), 64'd1);
    check("sp_outPixel", 64'(bus.outPixel), 64'h3C);
    check("sp_outBayer", 64'(bus.outBayer), 64'd2);
    check("sp_outCol", 64'(bus.outCol), 64'd165);
    idle(3, 1'b1);

    // Backpressure: only fifoDepth reads get credit.
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 22'(i), 2'(i), 11'd1, 11'(i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.memRe) begin
        check("bp_addr", 64'(bus.memAddr), 64'(reads));
        reads++;
      end
    end
    check("bp_reads", 64'(reads), 64'd4);
    check("bp_fifoCount", 64'(bus.fifoCount), 64'd4);
    check("bp_enOut", 64'(bus.enOut), 64'd0);
    check("bp_overflow", 64'(bus.overflowErr), 64'd0);
    idle(1, 1'b1);
    @(negedge clk);
    check("bp_pop_enOut", 64'(bus.enOut), 64'd0);
    check("bp_head0", 64'(bus.outPixel), 64'h99);
    idle(1, 1'b1);
    @(negedge clk);
    check("bp_credit_back", 64'(bus.enOut), 64'd1);
    check("bp_head1", 64'(bus.outPixel), 64'h98);
    idle(4, 1'b1);

    // Streaming at one pixel per cycle.
    n_out = 0; n_en_low = 0; first = -1; last = -1;
    for (int k = 0; k < 70; k++) begin
      if (k < 64) drive(1'b1, 22'(22'h100 + k), 2'(k), 11'd2, 11'(k), 1'b1, 1'b0, 1'b0);
      else        idle(1, 1'b1);
      @(negedge clk);
      if (!bus.enOut) n_en_low++;
      if (bus.outValid) begin
        if (first < 0) first = k;
        last = k;
        n_out++;
      end
    end
    check("st_count", 64'(n_out), 64'd64);
    check("st_first", 64'(first), 64'd3);
    check("st_last", 64'(last), 64'd66);
    check("st_en_low", 64'(n_en_low), 64'd0);
    idle(2, 1'b1);

    // Flush with two entries queued and two reads in flight.
    for (int k = 0; k < 4; k++) drive(1'b1, 22'(22'h200 + k), 2'(k), 11'd3, 11'(k), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 22'h2FF, 2'd3, 11'd3, 11'd9, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("fl_pre_count", 64'(bus.fifoCount), 64'd2);
    check("fl_pre_memRe", 64'(bus.memRe), 64'd0);
    drive(1'b1, 22'h210, 2'd1, 11'd3, 11'd16, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_count", 64'(bus.fifoCount), 64'd0);
    check("fl_outValid", 64'(bus.outValid), 64'd0);
    check("fl_memRe", 64'(bus.memRe), 64'd1);
    idle(2, 1'b1);
    @(negedge clk);
    check("fl_no_stale", 64'(bus.outValid), 64'd0);
    idle(1, 1'b1);
    @(negedge clk);
    check("fl_new_valid", 64'(bus.outValid), 64'd1);
    check("fl_new_pixel", 64'(bus.outPixel), 64'h89);
    idle(3, 1'b1);

    // Simultaneous push and pop with three entries queued.
    for (int k = 0; k < 4; k++) drive(1'b1, 22'(22'h300 + k), 2'(k), 11'd4, 11'(k), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    check("pp_count2", 64'(bus.fifoCount), 64'd2);
    idle(1, 1'b1);
    @(negedge clk);
    check("pp_count3", 64'(bus.fifoCount), 64'd3);
    check("pp_head0", 64'(bus.outPixel), 64'h99);
    idle(1, 1'b1);
    @(negedge clk);
    check("pp_count_hold", 64'(bus.fifoCount), 64'd3);
    check("pp_head1", 64'(bus.outPixel), 64'h98);
    check("pp_overflow", 64'(bus.overflowErr), 64'd0);
    idle(5, 1'b1);

    // Accept during start is discarded although the read is issued.
    drive(1'b1, 22'h3AA, 2'd1, 11'd5, 11'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("sa_memRe", 64'(bus.memRe), 64'd1);
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      idle(1, 1'b1);
      @(negedge clk);
      if (bus.outValid) stale++;
    end
    check("sa_no_output", 64'(stale), 64'd0);
    check("end_overflow", 64'(bus.overflowErr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
